// File: rtl/fifo_uart_tx_bridge.sv
// Drains 32-bit words from the CPU-to-host FIFO and serialises each one as four
// 8N1 UART bytes (LSB byte first), counting completed words.
module fifo_uart_tx_bridge #(
   parameter int CLK_HZ = 100_000_000,
   parameter int BAUD   = 115200
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [31:0] fifo_rd_data,
   input  logic        fifo_empty,
   output logic        fifo_rd_en,
   output logic        uart_txd,
   output logic        busy,
   output logic [15:0] word_count
);
   localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
   localparam int CNT_W = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   if (CLKS_PER_BIT < 2) begin : g_baud_check
      $error("fifo_uart_tx_bridge: CLK_HZ/BAUD must be at least 2");
   end

   typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, STOP} state_t;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [2:0]       bit_idx_reg, bit_idx_next;
   logic [1:0]       byte_idx_reg, byte_idx_next;
   logic [31:0]      shift_reg, shift_next;
   logic             txd_reg, txd_next;
   logic             rd_en_reg, rd_en_next;
   logic [15:0]      word_count_reg, word_count_next;

   logic bit_done;
   logic can_fetch;

   assign bit_done  = (cnt_reg == CNT_LAST);
   assign can_fetch = enable && !fifo_empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         cnt_reg        <= '0;
         bit_idx_reg    <= '0;
         byte_idx_reg   <= '0;
         shift_reg      <= '0;
         txd_reg        <= 1'b1;
         rd_en_reg      <= 1'b0;
         word_count_reg <= '0;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         bit_idx_reg    <= bit_idx_next;
         byte_idx_reg   <= byte_idx_next;
         shift_reg      <= shift_next;
         txd_reg        <= txd_next;
         rd_en_reg      <= rd_en_next;
         word_count_reg <= word_count_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      cnt_next        = cnt_reg;
      bit_idx_next    = bit_idx_reg;
      byte_idx_next   = byte_idx_reg;
      shift_next      = shift_reg;
      txd_next        = txd_reg;
      rd_en_next      = 1'b0;
      word_count_next = word_count_reg;

      case (state_reg)
         IDLE: begin
            if (can_fetch) begin
               state_next = FETCH;
               rd_en_next = 1'b1;
            end
         end
         FETCH: state_next = LOAD;
         LOAD: begin
            // Read data is valid one cycle after the strobe edge, i.e. here.
            shift_next    = fifo_rd_data;
            byte_idx_next = '0;
            cnt_next      = '0;
            txd_next      = 1'b0;
            state_next    = START;
         end
         START: begin
            if (bit_done) begin
               cnt_next     = '0;
               bit_idx_next = '0;
               txd_next     = shift_reg[0];
               state_next   = DATA;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         DATA: begin
            if (bit_done) begin
               cnt_next = '0;
               if (bit_idx_reg == 3'd7) begin
                  txd_next   = 1'b1;
                  state_next = STOP;
               end else begin
                  bit_idx_next = bit_idx_reg + 3'd1;
                  txd_next     = shift_reg[bit_idx_reg + 3'd1];
               end
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         STOP: begin
            if (bit_done) begin
               cnt_next = '0;
               if (byte_idx_reg != 2'd3) begin
                  byte_idx_next = byte_idx_reg + 2'd1;
                  shift_next    = {8'h00, shift_reg[31:8]};
                  txd_next      = 1'b0;
                  state_next    = START;
               end else begin
                  // Word complete; chain straight into the next read if allowed.
                  word_count_next = word_count_reg + 16'd1;
                  if (can_fetch) begin
                     state_next = FETCH;
                     rd_en_next = 1'b1;
                  end else begin
                     state_next = IDLE;
                  end
               end
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign fifo_rd_en = rd_en_reg;
   assign uart_txd   = txd_reg;
   assign busy       = (state_reg != IDLE);
   assign word_count = word_count_reg;

endmodule

// File: doc/fifo_uart_tx_bridge.md
# fifo_uart_tx_bridge

Drains 32-bit result words from the CPU-to-host FIFO (fifo2, written by the PicoRV32 at 0x3000_0008) and transmits each one on a UART TX line to the STM32, least-significant byte first, 8N1. The block is the stage directly downstream of fifo2. It owns the FIFO read port and the physical `uart_txd` pin. It also reports progress back to firmware-visible status.

## Interface
- `CLK_HZ`, default 100_000_000: clk frequency in Hz.
- `BAUD`, default 115200: UART bit rate. `CLKS_PER_BIT` = `CLK_HZ/BAUD`, integer division, truncated (868 at the defaults). It must be ≥ 2; elaboration fails otherwise.
- `clk`, in, 1: clock; all logic on the rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `enable`, in, 1: permits starting a new word. Typically tied to `loading_out`.
- `fifo_rd_data`, in, 32: FIFO read data, standard mode, read latency 1.
- `fifo_empty`, in, 1: FIFO empty flag.
- `fifo_rd_en`, out, 1: FIFO read strobe, registered, one-cycle pulse.
- `uart_txd`, out, 1: serial output, idle high.
- `busy`, out, 1: word in flight.
- `word_count`, out, 16: number of words fully transmitted; wraps.

## Operation
- States: IDLE, FETCH, LOAD, START, DATA, STOP.
- IDLE: if `enable && !fifo_empty`, go to FETCH and set `fifo_rd_en`=1 for exactly one cycle. Otherwise stay in IDLE.
- FETCH: `fifo_rd_en` returns to 0. Go to LOAD.
- LOAD: capture `fifo_rd_data` into a 32-bit shift word. Set the byte index to 0. Go to START and drive `uart_txd`=0.
- START: hold 0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
- DATA: drive bit[i] of the current byte, LSB first. Each bit lasts `CLKS_PER_BIT` cycles. After bit 7, go to STOP.
- STOP: drive 1 for `CLKS_PER_BIT` cycles. At the end of the stop bit:
  - If byte index < 3: increment it, shift the word right by 8, and go to START.
  - If byte index = 3 (word done): increment `word_count` (0xFFFF wraps to 0x0000). Then, if `enable && !fifo_empty`, go straight to FETCH and assert `fifo_rd_en`. Otherwise go to IDLE.
- Byte order: byte0 = word[7:0] first, byte3 = word[31:24] last.
- `busy` is 1 in every state except IDLE.
- Boundary rules:
  - `fifo_rd_en` is never asserted while `fifo_empty`=1.
  - At most one read is outstanding at any time.
  - `enable` falling mid-word does not abort; the current 4 bytes complete, then the block returns to IDLE.
  - `fifo_empty`/`fifo_rd_data` changes outside LOAD are ignored. Data is sampled only in LOAD.
  - `fifo_full` is not used by this block.
- Bit timing: one counter, width $clog2(`CLKS_PER_BIT`), reloaded at each bit boundary. No fractional-baud accumulation.

## Timing
- Reset values: `uart_txd`=1, `fifo_rd_en`=0, `busy`=0, `word_count`=0, state IDLE, counters 0.
- Reset mid-frame: `uart_txd`=1 on the reset edge. The in-flight word is discarded and not counted.
- Edge E0: IDLE samples `!fifo_empty && enable`. `fifo_rd_en`=1 and `busy`=1 during cycle E0..E1.
- Edge E1 (FETCH): `fifo_rd_en`=0.
- Edge E2 (LOAD): data captured. `uart_txd` falls at E2.
- Each byte lasts `10*CLKS_PER_BIT` cycles. A word occupies `40*CLKS_PER_BIT` cycles from its start-bit edge to its stop-end edge.
- The final stop bit ends at the edge that increments `word_count`. On that edge, `busy` drops if the next state is IDLE.
- Back-to-back words: the stop bit of byte3 is effectively stretched. Line-high time from the stop-bit start to the next start bit is `CLKS_PER_BIT`+2 cycles (FETCH and LOAD are 1 cycle each).
- Between bytes of the same word there is no extra gap: stop end → start begins on the same edge.

## Test plan
- Reset: `CLK_HZ`=1_000_000, `BAUD`=100_000 (`CLKS_PER_BIT`=10). Assert `rst` for 3 cycles → `uart_txd`=1, `busy`=0, `word_count`=0, `fifo_rd_en`=0.
- Single word: push 0x44332211 → exactly one `fifo_rd_en` pulse. A UART monitor decodes 0x11, 0x22, 0x33, 0x44 in order. The first start bit falls 2 cycles after the rd_en edge. The frame is 400 cycles, `word_count`=1, then `busy`=0.
- Back-to-back: preload 0xDEADBEEF and 0x00000013 → bytes EF BE AD DE 13 00 00 00. The second rd_en asserts on the stop-end edge of byte DE. The inter-word line-high time is 12 cycles. `word_count`=2.
- Enable gating: `enable`=0 with a non-empty FIFO → no rd_en for 1000 cycles. Drop `enable` 50 cycles into a word → that word completes and no further read occurs.
- Reset mid-frame: assert `rst` during byte1 of 0xCAFEF00D → `uart_txd`=1 at the reset edge and `word_count` stays 0. After release with an empty FIFO, the line stays idle.
- Counter wrap: force `word_count`=0xFFFF, send one word → `word_count`=0x0000. Also check that an empty FIFO never sees `fifo_rd_en`=1 across all tests.
